// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter (0 = fetch, 1 = data). One access at a time:
// IDLE accepts a request, ACCESS drives the memory for one cycle, RESP
// returns a single-cycle response strobe to the requester that was served.
module mem_arbiter #(
  parameter  int ADDR_WIDTH = 32,
  parameter  int BYTE_SIZE  = 4,
  parameter  int MEM_TOP    = 100,
  localparam int DW         = 8 * BYTE_SIZE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  // requester 0 (fetch)
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DW-1:0]         req0_wdata,
  output logic                  rsp0_valid,
  output logic [DW-1:0]         rsp0_rdata,
  output logic                  rsp0_err,
  // requester 1 (data)
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DW-1:0]         req1_wdata,
  output logic                  rsp1_valid,
  output logic [DW-1:0]         rsp1_rdata,
  output logic                  rsp1_err,
  // memory port
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DW-1:0]         mem_wd,
  input  logic [DW-1:0]         mem_rd
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // Request captured at acceptance; everything downstream works from this.
  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DW-1:0]         wdata;
    logic                  id;
    logic                  err;
  } req_t;

  // Range arithmetic is one bit wider than the address so addr near the top
  // of the address space cannot wrap back into range.
  localparam logic [ADDR_WIDTH:0] SPAN_M1 = (ADDR_WIDTH+1)'(BYTE_SIZE - 1);
  localparam logic [ADDR_WIDTH:0] TOP     = (ADDR_WIDTH+1)'(MEM_TOP);

  state_t        state_q, state_d;
  req_t          lat_q, lat_d;
  logic          last_grant_q, last_grant_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic                  sel;
  logic                  accept;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DW-1:0]         sel_wdata;
  logic [ADDR_WIDTH:0]   sel_end;
  logic                  sel_err;

  // Requester selection: a lone requester wins, a tie goes away from last_grant.
  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) sel = ~last_grant_q;
    else                          sel = req1_valid;
    accept     = (state_q == IDLE) && (req0_valid || req1_valid);
    req0_ready = accept && !sel;
    req1_ready = accept &&  sel;
    sel_we     = sel ? req1_we    : req0_we;
    sel_addr   = sel ? req1_addr  : req0_addr;
    sel_wdata  = sel ? req1_wdata : req0_wdata;
    sel_end    = {1'b0, sel_addr} + SPAN_M1;
    sel_err    = sel_end > TOP;
  end

  // Next-state: latch on acceptance, capture read data at the end of ACCESS.
  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    last_grant_d = last_grant_q;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          lat_d.we     = sel_we;
          lat_d.addr   = sel_addr;
          lat_d.wdata  = sel_wdata;
          lat_d.id     = sel;
          lat_d.err    = sel_err;
          last_grant_d = sel;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        rdata_d = (!lat_q.we && !lat_q.err) ? mem_rd : '0;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      lat_q        <= '0;
      last_grant_q <= 1'b1;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      last_grant_q <= last_grant_d;
      rdata_q      <= rdata_d;
    end
  end

  // Outputs decode registered state only, so reset drops mem_we at once and
  // no request input reaches the memory port combinationally.
  always_comb begin
    mem_we     = (state_q == ACCESS) && lat_q.we && !lat_q.err;
    mem_addr   = lat_q.addr;
    mem_wd     = lat_q.wdata;
    rsp0_valid = (state_q == RESP) && !lat_q.id;
    rsp1_valid = (state_q == RESP) &&  lat_q.id;
    rsp0_rdata = rsp0_valid ? rdata_q : '0;
    rsp1_rdata = rsp1_valid ? rdata_q : '0;
    rsp0_err   = rsp0_valid && lat_q.err;
    rsp1_err   = rsp1_valid && lat_q.err;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus tasks push expected responses,
// a negedge monitor pops and checks every response strobe.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req0_ready, req0_we;
  logic [31:0] req0_addr, req0_wdata;
  logic        rsp0_valid, rsp0_err;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we;
  logic [31:0] req1_addr, req1_wdata;
  logic        rsp1_valid, rsp1_err;
  logic [31:0] rsp1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  mem_arbiter #(.ADDR_WIDTH(32), .BYTE_SIZE(4), .MEM_TOP(100)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Byte memory, initialised to mem[i] = i+1 on the first edge (in reset).
  logic [7:0] mem [0:127];
  logic       mem_init = 1'b0;

  always_comb begin
    mem_rd = '0;
    for (int k = 0; k < 4; k++)
      if ({1'b0, mem_addr} + 33'(k) < 33'd128) mem_rd[8*k +: 8] = mem[7'(mem_addr + 32'(k))];
  end

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'(i + 1);
      mem_init <= 1'b1;
    end else if (mem_we) begin
      for (int k = 0; k < 4; k++)
        if ({1'b0, mem_addr} + 33'(k) < 33'd128) mem[7'(mem_addr + 32'(k))] <= mem_wd[8*k +: 8];
    end
  end

  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  exp_t q0[$], q1[$];
  int   acc0[$], acc1[$];
  int   grants[$];
  int   cyc = 0;
  int   we_cnt = 0;
  logic [31:0] we_addr = '0;
  int   n_cmp = 0, n_err = 0;
  int   w0, w1, we_before;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_rsp(input int n);
    exp_t        e;
    int          a;
    logic [31:0] rd;
    logic        er;
    logic [33:0] other;
    if (n == 0) begin rd = rsp0_rdata; er = rsp0_err; other = {rsp1_valid, rsp1_err, rsp1_rdata}; end
    else        begin rd = rsp1_rdata; er = rsp1_err; other = {rsp0_valid, rsp0_err, rsp0_rdata}; end
    if ((n == 0 && q0.size() == 0) || (n == 1 && q1.size() == 0)) begin
      n_cmp++; n_err++;
      $display("FAIL unexpected_rsp%0d: got a strobe expected none", n);
      return;
    end
    if (n == 0) begin e = q0.pop_front(); a = (acc0.size() != 0) ? acc0.pop_front() : -10; end
    else        begin e = q1.pop_front(); a = (acc1.size() != 0) ? acc1.pop_front() : -10; end
    chk($sformatf("rsp%0d_rdata", n), 64'(rd), 64'(e.rdata));
    chk($sformatf("rsp%0d_err", n), 64'(er), 64'(e.err));
    chk($sformatf("rsp%0d_latency", n), 64'(cyc), 64'(a + 1));
    chk($sformatf("rsp%0d_other_quiet", n), 64'(other), 64'd0);
  endtask

  // Monitor: grant order, memory write activity, response scoreboard.
  always @(negedge clk) begin
    if (req0_ready) grants.push_back(0);
    if (req1_ready) grants.push_back(1);
    if (mem_we) begin we_cnt++; we_addr = mem_addr; end
    if (rsp0_valid) check_rsp(0);
    if (rsp1_valid) check_rsp(1);
  end

  // Present one request, push its expected response, hold until accepted.
  task automatic do_req(input int n, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, output int waits);
    exp_t e;
    bit   got = 1'b0;
    e.rdata = exp_rd; e.err = exp_err;
    waits = 0;
    if (n == 0) begin q0.push_back(e); req0_we = we; req0_addr = addr; req0_wdata = wd; req0_valid = 1'b1; end
    else        begin q1.push_back(e); req1_we = we; req1_addr = addr; req1_wdata = wd; req1_valid = 1'b1; end
    while (!got && waits < 40) begin
      @(negedge clk);
      waits++;
      got = (n == 0) ? req0_ready : req1_ready;
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout%0d: got no ready expected ready within 40 cycles", n);
    end
    @(posedge clk); #1;
    if (n == 0) begin acc0.push_back(cyc); req0_valid = 1'b0; end
    else        begin acc1.push_back(cyc); req1_valid = 1'b0; end
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() + q1.size()) != 0 && n < 20) begin @(posedge clk); n++; end
    if ((q0.size() + q1.size()) != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q0.size() + q1.size());
    end
  endtask

  function automatic int order_code();
    int c = 0;
    foreach (grants[i]) c = c * 10 + grants[i] + 1;
    return c;
  endfunction

  initial begin
    reset_n = 1'b0;
    req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'({req0_ready, req1_ready}), 64'd0);
    chk("rst_rsp", 64'({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, rsp0_rdata, rsp1_rdata}), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wd", 64'(mem_wd), 64'd0);
    @(negedge clk); reset_n = 1'b1;

    // Tie after reset: read 0 on req0, write 8 on req1; req0 must go first.
    @(posedge clk); #1;
    grants.delete();
    fork
      do_req(0, 1'b0, 32'd0, 32'd0, 32'h04030201, 1'b0, w0);
      do_req(1, 1'b1, 32'd8, 32'hDEADBEEF, 32'd0, 1'b0, w1);
    join
    drain();
    chk("tie_order", 64'(order_code()), 64'd12);
    chk("wr8_we_cycles", 64'(we_cnt), 64'd1);
    chk("wr8_we_addr", 64'(we_addr), 64'd8);

    // Both held for four requests: strict alternation 0,1,0,1.
    @(posedge clk); #1;
    grants.delete();
    fork
      begin
        do_req(0, 1'b0, 32'd4, 32'd0, 32'h08070605, 1'b0, w0);
        do_req(0, 1'b0, 32'd0, 32'd0, 32'h04030201, 1'b0, w0);
      end
      begin
        do_req(1, 1'b0, 32'd8,  32'd0, 32'hDEADBEEF, 1'b0, w1);
        do_req(1, 1'b0, 32'd12, 32'd0, 32'h100F0E0D, 1'b0, w1);
      end
    join
    drain();
    chk("alt_order", 64'(order_code()), 64'd1212);

    // Back-pressure: req0 arrives during req1's ACCESS, waits out ACCESS+RESP.
    // Also the range edge: 97..100 is in range, 98..101 is not.
    @(posedge clk); #1;
    fork
      do_req(1, 1'b0, 32'd97, 32'd0, 32'h65646362, 1'b0, w1);
      begin
        @(posedge clk); #1;
        do_req(0, 1'b0, 32'd98, 32'd0, 32'd0, 1'b1, w0);
      end
    join
    drain();
    chk("bp_wait_cycles", 64'(w0), 64'd3);

    // Write at the top of the address space: error, memory untouched.
    we_before = we_cnt;
    @(posedge clk); #1;
    do_req(0, 1'b1, 32'hFFFFFFFF, 32'hCAFEF00D, 32'd0, 1'b1, w0);
    drain();
    chk("errwr_no_we", 64'(we_cnt), 64'(we_before));

    // Reset during ACCESS of a write: mem_we drops asynchronously, no response.
    @(posedge clk); #1;
    req1_we = 1'b1; req1_addr = 32'd16; req1_wdata = 32'hA5A5A5A5; req1_valid = 1'b1;
    @(negedge clk);
    chk("mid_ready", 64'(req1_ready), 64'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    chk("mid_we_before_rst", 64'(mem_we), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_we_async_drop", 64'(mem_we), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("mid_rst_rsp", 64'({rsp0_valid, rsp1_valid}), 64'd0);

    // Release reset with a request ready: accepted on the first edge after,
    // and the aborted write left bytes 16..19 unchanged.
    reset_n = 1'b1;
    do_req(0, 1'b0, 32'd16, 32'd0, 32'h14131211, 1'b0, w0);
    chk("first_accept_wait", 64'(w0), 64'd1);
    drain();

    repeat (4) @(posedge clk);
    #1;
    chk("queues_empty", 64'(q0.size() + q1.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte-address width of both requesters and the memory port.
REQ-002 Parameter BYTE_SIZE, default 4, bytes per access; data width DW = 8*BYTE_SIZE.
REQ-003 Parameter MEM_TOP, default 100, highest valid byte address of the attached memory.
REQ-004 Ports: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 reqN_valid  input  1  requester N (N=0 fetch, N=1 data) presents a request.
REQ-008 reqN_ready  output  1  arbiter accepts requester N's request this cycle.
REQ-009 reqN_we  input  1  1 = write, 0 = read.
REQ-010 reqN_addr  input  ADDR_WIDTH  byte address of the access.
REQ-011 reqN_wdata  input  DW  write data, byte k at bits [8k+7:8k].
REQ-012 rspN_valid  output  1  one-cycle response strobe to requester N.
REQ-013 rspN_rdata  output  DW  read data; 0 for writes and errors.
REQ-014 rspN_err  output  1  out-of-range access flag, valid with rspN_valid.
REQ-015 mem_we  output  1  memory write enable.
REQ-016 mem_addr  output  ADDR_WIDTH  memory byte address.
REQ-017 mem_wd  output  DW  memory write data.
REQ-018 mem_rd  input  DW  memory combinational read data.

Function
REQ-019 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on acceptance, ACCESS->RESP always, RESP->IDLE always.
REQ-020 Accept: in IDLE only; reqN_ready = 1 combinationally for exactly the selected requester when it is valid; handshake completes on a rising edge with valid && ready.
REQ-021 Selection: one valid requester -> it is selected; both valid -> requester other than last_grant; last_grant updates on every acceptance.
REQ-022 On acceptance latch we, addr, wdata, requester id, and err = (addr + BYTE_SIZE - 1 > MEM_TOP), computed in ADDR_WIDTH+1 bits so no wrap-around.
REQ-023 ACCESS: mem_addr = latched addr, mem_wd = latched wdata, mem_we = latched we && !err, for exactly one cycle; mem_we = 0 in every other state.
REQ-024 End of ACCESS: register mem_rd into response data if read && !err, else 0.
REQ-025 RESP: rspN_valid = 1 for exactly one cycle on the latched requester only, with rspN_rdata and rspN_err; the other port's rsp outputs stay 0.
REQ-026 Latency: acceptance edge T, memory write edge T+1, rspN_valid high in the cycle after edge T+1; next acceptance no earlier than edge T+3.
REQ-027 Requests that arrive during ACCESS/RESP see ready = 0 and must be held by the requester; the arbiter never drops a held request.
REQ-028 Erroneous writes never assert mem_we; erroneous reads return rdata = 0, err = 1.
REQ-029 mem_addr and mem_wd hold their latched values outside ACCESS; no combinational path from reqN inputs to any mem_* output.

Reset
REQ-030 While reset_n = 0: state = IDLE, last_grant = 1 (requester 0 wins the first tie), all reqN_ready/rspN_* = 0, mem_we = 0, mem_addr = 0, mem_wd = 0, latched fields = 0.
REQ-031 Reset asserted mid-ACCESS drops mem_we immediately (asynchronously) and aborts the pending response; no rsp strobe follows reset release.
REQ-032 First acceptance is possible on the first rising edge after reset_n deasserts.

Verification
REQ-033 Read: mem bytes 0..3 = 01,02,03,04; req0 read addr 0 -> rsp0_valid 2 cycles after accept, rdata 0x04030201, err 0.
REQ-034 Write then read: req1 write addr 8 data 0xDEADBEEF -> mem_we high one cycle at addr 8; then req1 read addr 8 -> rdata 0xDEADBEEF.
REQ-035 Tie after reset: both valid same cycle -> req0 accepted first, req1 next; held together for 4 requests -> grant order 0,1,0,1.
REQ-036 Range: read addr 97 -> err 0; read addr 98 -> err 1, rdata 0; write addr 0xFFFFFFFF -> err 1, mem_we never asserted.
REQ-037 Reset mid-write: assert reset_n = 0 during ACCESS of a write -> mem_we falls without a clock edge, no rsp strobe, target bytes unchanged.
REQ-038 Back-pressure: req0 valid during req1's ACCESS -> req0_ready = 0 until IDLE, then accepted with the unchanged held request.
